// File: rtl/reg_dump_reader.sv
// Streams a run of consecutive register-file words out over valid/ready.
// Optional out_parity output when REG_DUMP_PARITY_EN is defined.
module reg_dump_reader #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              clk_n,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
`ifdef REG_DUMP_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W:0]   NumRegsCnt = CntW'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W:0]     count_clamped;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  assign count_clamped = (count > NumRegsCnt) ? NumRegsCnt : count;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rf_addr_d   = rf_addr_q;
    out_addr_d  = out_addr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            state_d   = StIssue;
            addr_d    = first_addr;
            rf_addr_d = first_addr;
            rem_d     = count_clamped;
          end else begin
            state_d = StFin;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // Read data is valid exactly one edge after the ISSUE cycle.
        out_data_d  = rf_rdata;
        out_addr_d  = addr_q;
        out_valid_d = 1'b1;
        rem_d       = rem_q - 1'b1;
        addr_d      = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rem_q != '0) begin
            state_d   = StIssue;
            rf_addr_d = addr_q;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk_n) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rf_addr_q   <= '0;
      out_addr_q  <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rf_addr_q   <= rf_addr_d;
      out_addr_q  <= out_addr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign rf_rd_en  = (state_q == StIssue);
  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

`ifdef REG_DUMP_PARITY_EN
  logic out_parity_q;

  always_ff @(negedge clk_n) begin
    if (rst) begin
      out_parity_q <= 1'b0;
    end else if (state_q == StWait) begin
      out_parity_q <= ^rf_rdata;
    end
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench for reg_dump_reader with a behavioural register file model.
module tb_reg_dump_reader;

  logic        clk_n;
  logic        rst;
  logic        start;
  logic [2:0]  first_addr;
  logic [3:0]  count;
  logic        busy, done, rf_rd_en, out_valid, out_ready;
  logic [2:0]  rf_addr, out_addr;
  logic [15:0] rf_rdata, out_data;
`ifdef REG_DUMP_PARITY_EN
  logic        out_parity;
`endif

  reg_dump_reader dut (
    .clk_n     (clk_n),
    .rst       (rst),
    .start     (start),
    .first_addr(first_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rf_rd_en  (rf_rd_en),
    .rf_addr   (rf_addr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
`ifdef REG_DUMP_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] regs [8];
  logic [2:0]  got_addr [$];
  logic [15:0] got_data [$];
  logic [2:0]  exp_addr [$];
  logic [15:0] exp_data [$];
  int rd_cnt, done_cnt, edge_n, done_edge, par_err;
  int ready_mode;

  initial begin
    clk_n = 1'b1;
    forever #5 clk_n = ~clk_n;
  end

  // Register file: synchronous read, data valid one falling edge after the strobe.
  always @(negedge clk_n) begin
    if (rf_rd_en) rf_rdata <= regs[rf_addr];
  end

  // Observes pre-edge values at each active edge.
  always @(negedge clk_n) begin
    if (!rst) begin
      if (rf_rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        done_edge = edge_n;
      end
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
`ifdef REG_DUMP_PARITY_EN
        if (out_parity !== ^out_data) par_err++;
`endif
      end
    end
    edge_n++;
  end

  task automatic build_exp(input logic [2:0] fa, input logic [3:0] cnt);
    int n;
    n = (cnt > 4'd8) ? 8 : int'(cnt);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(3'((int'(fa) + i) % 8));
      exp_data.push_back(regs[(int'(fa) + i) % 8]);
    end
  endtask

  function automatic int words_bad();
    int bad;
    bad = 0;
    if (got_addr.size() != exp_addr.size()) return 1000 + got_addr.size();
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) bad++;
    end
    return bad;
  endfunction

  function automatic logic next_ready();
    if (ready_mode == 2) return 1'($urandom_range(0, 1));
    return (ready_mode == 1);
  endfunction

  task automatic rand_regs();
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
  endtask

  // Returns right after the posedge following the sampling edge N.
  task automatic start_dump(input logic [2:0] fa, input logic [3:0] cnt, input int mode,
                            output int st_edge);
    @(posedge clk_n);
    got_addr.delete();
    got_data.delete();
    rd_cnt     = 0;
    done_cnt   = 0;
    done_edge  = -1;
    ready_mode = mode;
    build_exp(fa, cnt);
    start      = 1'b1;
    first_addr = fa;
    count      = cnt;
    out_ready  = next_ready();
    st_edge    = edge_n;
    @(posedge clk_n);
    start      = 1'b0;
  endtask

  task automatic wait_done(output bit fin);
    fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != 0) begin
        fin = 1'b1;
        break;
      end
      out_ready = next_ready();
      @(posedge clk_n);
    end
    out_ready = 1'b0;
    repeat (3) @(posedge clk_n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_n);
    checks += 7;
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (rf_rd_en !== 1'b0)  begin errors++; $display("FAIL reset_rd_en got %b want 0", rf_rd_en); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (rf_addr !== 3'd0)   begin errors++; $display("FAIL reset_rf_addr got %0d want 0", rf_addr); end
    if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    if (out_addr !== 3'd0)  begin errors++; $display("FAIL reset_addr got %0d want 0", out_addr); end
`ifdef REG_DUMP_PARITY_EN
    checks++;
    if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", out_parity); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int  st;
    bit  fin;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
    start_dump(3'd2, 4'd3, 1, st);
    checks += 3;
    if (rf_rd_en !== 1'b1) begin errors++; $display("FAIL basic_rd_n1 got %b want 1", rf_rd_en); end
    if (rf_addr !== 3'd2)  begin errors++; $display("FAIL basic_rf_addr got %0d want 2", rf_addr); end
    if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    @(posedge clk_n);
    checks += 2;
    if (rf_rd_en !== 1'b0)  begin errors++; $display("FAIL basic_rd_n2 got %b want 0", rf_rd_en); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n2 got %b want 0", out_valid); end
    @(posedge clk_n);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 3'd2 || out_data !== 16'h1002) begin
      errors++;
      $display("FAIL basic_first_word got v=%b a=%0d d=%h want v=1 a=2 d=1002",
               out_valid, out_addr, out_data);
    end
    wait_done(fin);
    checks += 5;
    if (!fin) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    if (words_bad() != 0) begin
      errors++; $display("FAIL basic_words got %0d bad want 0", words_bad());
    end
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    if (rd_cnt != 3)   begin errors++; $display("FAIL basic_rd_cnt got %0d want 3", rd_cnt); end
    if (done_edge - st != 10) begin
      errors++; $display("FAIL basic_throughput got %0d want 10", done_edge - st);
    end
  endtask

  task automatic test_wrap();
    int st;
    bit fin;
    rand_regs();
    start_dump(3'd6, 4'd4, 1, st);
    wait_done(fin);
    checks += 3;
    if (!fin) begin errors++; $display("FAIL wrap_timeout got no done want done"); end
    if (words_bad() != 0) begin
      errors++; $display("FAIL wrap_words got %0d bad want 0", words_bad());
    end
    if (rd_cnt != 4) begin errors++; $display("FAIL wrap_rd_cnt got %0d want 4", rd_cnt); end
  endtask

  task automatic test_backpressure();
    int          st, hold, unstable;
    bit          fin;
    logic [2:0]  snap_a;
    logic [15:0] snap_d;
    rand_regs();
    hold = 0;
    unstable = 0;
    fin = 1'b0;
    start_dump(3'($urandom_range(0, 7)), 4'd3, 0, st);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != 0) begin
        fin = 1'b1;
        break;
      end
      if (out_valid) begin
        if (hold == 0) begin
          snap_a = out_addr;
          snap_d = out_data;
        end else if (out_addr !== snap_a || out_data !== snap_d) begin
          unstable++;
        end
        if (hold < 5) begin
          out_ready = 1'b0;
          hold++;
        end else begin
          out_ready = 1'b1;
          hold = 0;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(posedge clk_n);
    end
    out_ready = 1'b0;
    repeat (2) @(posedge clk_n);
    checks += 4;
    if (!fin) begin errors++; $display("FAIL bp_timeout got no done want done"); end
    if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    if (words_bad() != 0) begin
      errors++; $display("FAIL bp_words got %0d bad want 0", words_bad());
    end
    if (rd_cnt != 3) begin errors++; $display("FAIL bp_rd_cnt got %0d want 3", rd_cnt); end
  endtask

  task automatic test_zero_and_ignore();
    int         st;
    bit         fin;
    logic [2:0] fa;
    start_dump(3'd5, 4'd0, 1, st);
    wait_done(fin);
    checks += 3;
    if (!fin) begin errors++; $display("FAIL zero_timeout got no done want done"); end
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
    if (rd_cnt != 0)   begin errors++; $display("FAIL zero_rd_cnt got %0d want 0", rd_cnt); end
    rand_regs();
    fa = 3'($urandom_range(0, 7));
    start_dump(fa, 4'd3, 1, st);
    @(posedge clk_n);
    start      = 1'b1;
    first_addr = fa + 3'd4;
    count      = 4'd7;
    @(posedge clk_n);
    start = 1'b0;
    @(posedge clk_n);
    start = 1'b1;
    @(posedge clk_n);
    start = 1'b0;
    wait_done(fin);
    checks += 4;
    if (!fin) begin errors++; $display("FAIL ignore_timeout got no done want done"); end
    if (words_bad() != 0) begin
      errors++; $display("FAIL ignore_words got %0d bad want 0", words_bad());
    end
    if (rd_cnt != 3)   begin errors++; $display("FAIL ignore_rd_cnt got %0d want 3", rd_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got %b want 0", busy); end
  endtask

  task automatic test_random();
    int         st;
    bit         fin;
    logic [2:0] fa;
    logic [3:0] cnt;
    for (int k = 0; k < 8; k++) begin
      rand_regs();
      fa  = 3'($urandom_range(0, 7));
      cnt = 4'($urandom_range(0, 15));
      start_dump(fa, cnt, 2, st);
      wait_done(fin);
      checks += 3;
      if (!fin) begin errors++; $display("FAIL rand%0d_timeout got no done want done", k); end
      if (words_bad() != 0) begin
        errors++;
        $display("FAIL rand%0d_words fa=%0d cnt=%0d got %0d bad want 0", k, fa, cnt, words_bad());
      end
      if (rd_cnt != exp_addr.size()) begin
        errors++;
        $display("FAIL rand%0d_rd_cnt got %0d want %0d", k, rd_cnt, exp_addr.size());
      end
    end
  endtask

  task automatic test_reset_in_hold();
    int st;
    bit fin, seen;
    rand_regs();
    start_dump(3'($urandom_range(0, 7)), 4'd3, 0, st);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_n);
    end
    rst = 1'b1;
    @(posedge clk_n);
    checks += 5;
    if (!seen) begin errors++; $display("FAIL rsthold_reach got no valid want valid"); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rsthold_busy got %b want 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid got %b want 0", out_valid); end
    if (out_data !== 16'd0) begin errors++; $display("FAIL rsthold_data got %h want 0", out_data); end
    if (rf_addr !== 3'd0)   begin errors++; $display("FAIL rsthold_rf_addr got %0d want 0", rf_addr); end
    rst = 1'b0;
    repeat (4) @(posedge clk_n);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL rsthold_no_done got %0d want 0", done_cnt); end
    start_dump(3'($urandom_range(0, 7)), 4'd5, 2, st);
    wait_done(fin);
    checks += 2;
    if (!fin) begin errors++; $display("FAIL rsthold_restart got no done want done"); end
    if (words_bad() != 0) begin
      errors++; $display("FAIL rsthold_words got %0d bad want 0", words_bad());
    end
`ifdef REG_DUMP_PARITY_EN
    checks++;
    if (par_err != 0) begin errors++; $display("FAIL parity got %0d bad want 0", par_err); end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    first_addr = '0;
    count      = '0;
    out_ready  = 1'b0;
    rf_rdata   = '0;
    rd_cnt     = 0;
    done_cnt   = 0;
    edge_n     = 0;
    done_edge  = -1;
    par_err    = 0;
    ready_mode = 0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_ignore();
    test_random();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
